// File: rtl/npu_cmd_queue_pkg.sv
// Shared types and encodings for the NPU command queue: custom-0 opcode fields,
// NPU operation codes, the queued command record and the dispatcher states.
package npu_cmd_queue_pkg;

  localparam int NPU_XLEN = 64;

  localparam logic [6:0] OPCODE_CUSTOM0     = 7'b000_1011;
  localparam logic [6:0] FUNCT7_MATRIX_MUL  = 7'b000_0001;
  localparam logic [6:0] FUNCT7_CONVOLUTION = 7'b000_0010;

  localparam logic [1:0] NPU_OP_NONE   = 2'b00;
  localparam logic [1:0] NPU_OP_MATMUL = 2'b01;
  localparam logic [1:0] NPU_OP_CONV   = 2'b10;

  typedef enum logic {
    Q_IDLE,
    Q_WAIT
  } npu_q_state_e;

  typedef struct packed {
    logic [1:0]          op;
    logic [2:0]          funct3;
    logic [4:0]          rd;
    logic [NPU_XLEN-1:0] a;
    logic [NPU_XLEN-1:0] b;
  } npu_cmd_t;

  // NPU_OP_NONE marks a word that must not be enqueued.
  function automatic logic [1:0] npu_decode_op(input logic [31:0] instr);
    logic [1:0] op;
    op = NPU_OP_NONE;
    if (instr[6:0] == OPCODE_CUSTOM0) begin
      if (instr[31:25] == FUNCT7_MATRIX_MUL)       op = NPU_OP_MATMUL;
      else if (instr[31:25] == FUNCT7_CONVOLUTION) op = NPU_OP_CONV;
    end
    return op;
  endfunction

endpackage

// File: rtl/npu_cmd_queue_if.sv
// Issue, NPU request/response and writeback signals of the command queue.
// Suffixes _i/_o are from the queue's point of view; the queue uses modport slave.
interface npu_cmd_queue_if #(
  parameter int XLEN = 64
);
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [31:0]     issue_instr_i;
  logic [XLEN-1:0] issue_rs1_i;
  logic [XLEN-1:0] issue_rs2_i;
  logic            illegal_o;
  logic            npu_req_valid_o;
  logic            npu_req_ready_i;
  logic [1:0]      npu_req_op_o;
  logic [2:0]      npu_req_funct3_o;
  logic [XLEN-1:0] npu_req_a_o;
  logic [XLEN-1:0] npu_req_b_o;
  logic            npu_rsp_valid_i;
  logic [XLEN-1:0] npu_rsp_data_i;
  logic            wb_valid_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            busy_o;
  logic            timeout_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i,
           npu_req_ready_i, npu_rsp_valid_i, npu_rsp_data_i,
    input  issue_ready_o, illegal_o, npu_req_valid_o, npu_req_op_o,
           npu_req_funct3_o, npu_req_a_o, npu_req_b_o,
           wb_valid_o, wb_rd_o, wb_data_o, busy_o, timeout_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i,
           npu_req_ready_i, npu_rsp_valid_i, npu_rsp_data_i,
    output issue_ready_o, illegal_o, npu_req_valid_o, npu_req_op_o,
           npu_req_funct3_o, npu_req_a_o, npu_req_b_o,
           wb_valid_o, wb_rd_o, wb_data_o, busy_o, timeout_o
  );
endinterface

// File: rtl/npu_cmd_fifo.sv
// Circular buffer of DEPTH npu_cmd_t entries (DEPTH a power of two, >= 2).
// Push when full and pop when empty are ignored.
module npu_cmd_fifo
  import npu_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  npu_cmd_t               wdata_i,
  input  logic                   pop_i,
  output npu_cmd_t               rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  npu_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after being written, and count gates that.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/npu_cmd_queue.sv
// Decodes custom-0 NPU instructions into a command FIFO, dispatches one at a time,
// and turns each response into a writeback. Optional watchdog: NPU_TIMEOUT_EN.
module npu_cmd_queue
  import npu_cmd_queue_pkg::*;
#(
  parameter int XLEN           = NPU_XLEN, // must equal NPU_XLEN (width of npu_cmd_t operands)
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst_n,
  npu_cmd_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  npu_cmd_t        wcmd, head;
  logic            fifo_full, fifo_empty, push, pop, accept, legal;
  logic [CW-1:0]   fifo_count;
  logic [1:0]      dec_op;

  npu_q_state_e    state_q, state_d;
  logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_valid_q, wb_valid_d, illegal_q, illegal_d, timeout_q, timeout_d;

  assign dec_op = npu_decode_op(bus.issue_instr_i);
  assign legal  = (dec_op != NPU_OP_NONE);
  assign accept = bus.issue_valid_i && bus.issue_ready_o;
  assign push   = accept && legal && !fifo_full;
  assign pop    = (state_q == Q_IDLE) && !fifo_empty && bus.npu_req_ready_i;
  assign wcmd   = '{op: dec_op, funct3: bus.issue_instr_i[14:12], rd: bus.issue_instr_i[11:7],
                    a: bus.issue_rs1_i, b: bus.issue_rs2_i};

  npu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wcmd),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef NPU_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           expired;
  assign expired = (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    illegal_d  = accept && !legal;
    timeout_d  = 1'b0;
`ifdef NPU_TIMEOUT_EN
    tcnt_d     = '0;
`endif
    case (state_q)
      Q_IDLE: begin
        if (pop) begin
          state_d = Q_WAIT;
          rd_d    = head.rd;
        end
      end
      Q_WAIT: begin
`ifdef NPU_TIMEOUT_EN
        tcnt_d = tcnt_q + TCW'(1);
`endif
        // A response in the expiry cycle takes priority over the watchdog.
        if (bus.npu_rsp_valid_i) begin
          state_d    = Q_IDLE;
          wb_valid_d = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = bus.npu_rsp_data_i;
`ifdef NPU_TIMEOUT_EN
        end else if (expired) begin
          state_d   = Q_IDLE;
          timeout_d = 1'b1;
`endif
        end
      end
      default: state_d = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= Q_IDLE;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef NPU_TIMEOUT_EN
      tcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
`ifdef NPU_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
`endif
    end
  end

  // Request fields are gated so an idle channel shows zeros, not stale storage.
  assign bus.issue_ready_o    = (fifo_count < CW'(DEPTH));
  assign bus.npu_req_valid_o  = (state_q == Q_IDLE) && !fifo_empty;
  assign bus.npu_req_op_o     = bus.npu_req_valid_o ? head.op     : '0;
  assign bus.npu_req_funct3_o = bus.npu_req_valid_o ? head.funct3 : '0;
  assign bus.npu_req_a_o      = bus.npu_req_valid_o ? head.a      : '0;
  assign bus.npu_req_b_o      = bus.npu_req_valid_o ? head.b      : '0;
  assign bus.illegal_o        = illegal_q;
  assign bus.wb_valid_o       = wb_valid_q;
  assign bus.wb_rd_o          = wb_rd_q;
  assign bus.wb_data_o        = wb_data_q;
  assign bus.busy_o           = !fifo_empty || (state_q == Q_WAIT);
  assign bus.timeout_o        = timeout_q;

endmodule

// File: tb/tb_npu_cmd_queue.sv
// Self-checking bench for npu_cmd_queue: a queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_npu_cmd_queue;
  import npu_cmd_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef NPU_TIMEOUT_EN
  localparam int TO = 8;
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam int TO = 1024;
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npu_cmd_queue_if #(.XLEN(64)) ifc ();

  npu_cmd_queue #(.XLEN(64), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
  } mcmd_t;

  mcmd_t       mq[$];
  bit          waiting;
  logic [4:0]  wait_rd;
  int          wait_cnt;
  bit          e_wb_valid, e_illegal, e_timeout;
  logic [4:0]  e_wb_rd;
  logic [63:0] e_wb_data;

  function automatic logic [1:0] ref_op(input logic [31:0] w);
    logic [6:0] opc, f7;
    opc = w[6:0];
    f7  = w[31:25];
    if (opc != 7'h0B) return 2'b00;
    if (f7 == 7'd1) return 2'b01;
    if (f7 == 7'd2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    mq.delete();
    waiting = 0; wait_rd = '0; wait_cnt = 0;
    e_wb_valid = 0; e_illegal = 0; e_timeout = 0; e_wb_rd = '0; e_wb_data = '0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      bit         acc;
      logic [1:0] op;
      mcmd_t      c;
      acc = ifc.issue_valid_i && (mq.size() < DEPTH);
      op  = ref_op(ifc.issue_instr_i);
      e_illegal  = acc && (op == 2'b00);
      e_wb_valid = 0;
      e_timeout  = 0;
      if (waiting) begin
        if (ifc.npu_rsp_valid_i) begin
          waiting    = 0;
          e_wb_valid = (wait_rd != 0);
          e_wb_rd    = wait_rd;
          e_wb_data  = ifc.npu_rsp_data_i;
        end else begin
          wait_cnt++;
          if (TIMEOUT_ON && wait_cnt == TO) begin
            waiting   = 0;
            e_timeout = 1;
          end
        end
      end else if (mq.size() > 0 && ifc.npu_req_ready_i) begin
        wait_rd  = mq[0].rd;
        void'(mq.pop_front());
        waiting  = 1;
        wait_cnt = 0;
      end
      if (acc && op != 2'b00) begin
        c.op = op; c.f3 = ifc.issue_instr_i[14:12]; c.rd = ifc.issue_instr_i[11:7];
        c.a = ifc.issue_rs1_i; c.b = ifc.issue_rs2_i;
        mq.push_back(c);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_req;
    if (!rst_n) model_reset();
    exp_req = !waiting && (mq.size() > 0);
    check("issue_ready", ifc.issue_ready_o, mq.size() < DEPTH);
    check("req_valid", ifc.npu_req_valid_o, exp_req);
    check("busy", ifc.busy_o, (mq.size() > 0) || waiting);
    check("illegal", ifc.illegal_o, e_illegal);
    check("wb_valid", ifc.wb_valid_o, e_wb_valid);
    check("timeout", ifc.timeout_o, e_timeout);
    if (exp_req) begin
      check("req_op", ifc.npu_req_op_o, mq[0].op);
      check("req_funct3", ifc.npu_req_funct3_o, mq[0].f3);
      check("req_a", ifc.npu_req_a_o, mq[0].a);
      check("req_b", ifc.npu_req_b_o, mq[0].b);
    end
    if (e_wb_valid) begin
      check("wb_rd", ifc.wb_rd_o, e_wb_rd);
      check("wb_data", ifc.wb_data_o, e_wb_data);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h0B};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #2;
  endtask

  task automatic push(input logic [31:0] w, input logic [63:0] a, input logic [63:0] b);
    ifc.issue_valid_i = 1'b1;
    ifc.issue_instr_i = w;
    ifc.issue_rs1_i   = a;
    ifc.issue_rs2_i   = b;
    step();
    ifc.issue_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [63:0] d);
    ifc.npu_rsp_valid_i = 1'b1;
    ifc.npu_rsp_data_i  = d;
    step();
    ifc.npu_rsp_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.issue_valid_i = 0; ifc.issue_instr_i = '0; ifc.issue_rs1_i = '0; ifc.issue_rs2_i = '0;
    ifc.npu_req_ready_i = 1; ifc.npu_rsp_valid_i = 0; ifc.npu_rsp_data_i = '0;

    // Reset state.
    repeat (2) step();
    check("rst issue_ready", ifc.issue_ready_o, 1);
    check("rst req_valid", ifc.npu_req_valid_o, 0);
    check("rst busy", ifc.busy_o, 0);
    check("rst wb_valid", ifc.wb_valid_o, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    step();

    // MATMUL rd=5, operands 3/4, response 0xAB.
    push(32'h0220828B, 64'd3, 64'd4);
    sample();
    check("t1 req_valid", ifc.npu_req_valid_o, 1);
    check("t1 op", ifc.npu_req_op_o, 2'b01);
    check("t1 a", ifc.npu_req_a_o, 64'd3);
    check("t1 b", ifc.npu_req_b_o, 64'd4);
    step();
    sample();
    check("t1 wait req_valid", ifc.npu_req_valid_o, 0);
    check("t1 wait busy", ifc.busy_o, 1);
    respond(64'hAB);
    sample();
    check("t1 wb_valid", ifc.wb_valid_o, 1);
    check("t1 wb_rd", ifc.wb_rd_o, 5'd5);
    check("t1 wb_data", ifc.wb_data_o, 64'hAB);
    sample();
    check("t1 wb pulse", ifc.wb_valid_o, 0);
    check("t1 idle busy", ifc.busy_o, 0);

    // CONV rd=6, then an illegal funct7.
    push(32'h0420830B, 64'd7, 64'd8);
    sample();
    check("t2 op", ifc.npu_req_op_o, 2'b10);
    step();
    respond(64'h55);
    sample();
    check("t2 wb_rd", ifc.wb_rd_o, 5'd6);
    push(32'h0620828B, 64'd1, 64'd1);
    sample();
    check("t2 illegal", ifc.illegal_o, 1);
    check("t2 no req", ifc.npu_req_valid_o, 0);
    check("t2 not busy", ifc.busy_o, 0);
    sample();
    check("t2 illegal pulse", ifc.illegal_o, 0);

    // Fill with NPU stalled: fifth offer is refused.
    ifc.npu_req_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      ifc.issue_valid_i = 1;
      ifc.issue_instr_i = mk((i % 2 == 0) ? 7'd1 : 7'd2, 3'(i), 5'(i + 1));
      ifc.issue_rs1_i   = 64'(i * 16);
      ifc.issue_rs2_i   = ~64'(i);
      step();
    end
    ifc.issue_valid_i = 0;
    sample();
    check("t3 full ready", ifc.issue_ready_o, 0);
    check("t3 full req_valid", ifc.npu_req_valid_o, 1);
    ifc.npu_req_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      respond(64'h1000 + 64'(i));
      sample();
      check("t3 drain wb_valid", ifc.wb_valid_o, 1);
      check("t3 drain wb_rd", ifc.wb_rd_o, 5'(i + 1));
      check("t3 drain wb_data", ifc.wb_data_o, 64'h1000 + 64'(i));
    end
    sample();
    check("t3 drained busy", ifc.busy_o, 0);

    // rd = 0 executes but produces no writeback.
    push(mk(7'd1, 3'd0, 5'd0), 64'd9, 64'd9);
    sample();
    check("t4 req_valid", ifc.npu_req_valid_o, 1);
    step();
    respond(64'hDEAD);
    sample();
    check("t4 wb suppressed", ifc.wb_valid_o, 0);
    check("t4 busy", ifc.busy_o, 0);

    // Reset while WAIT with two queued entries, then a stale response.
    for (int i = 0; i < 3; i++) begin
      ifc.issue_valid_i = 1;
      ifc.issue_instr_i = mk(7'd1, 3'd0, 5'(10 + i));
      step();
    end
    ifc.issue_valid_i = 0;
    check("t5 busy before", ifc.busy_o, 1);
    check("t5 ready before", ifc.issue_ready_o, 1);
    rst_n = 1'b0;
    #1;
    check("t5 rst req_valid", ifc.npu_req_valid_o, 0);
    check("t5 rst busy", ifc.busy_o, 0);
    check("t5 rst ready", ifc.issue_ready_o, 1);
    check("t5 rst wb_valid", ifc.wb_valid_o, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    sample();
    respond(64'h99);
    sample();
    check("t5 stale wb", ifc.wb_valid_o, 0);
    check("t5 stale busy", ifc.busy_o, 0);

`ifdef NPU_TIMEOUT_EN
    // No response: timeout after 8 WAIT cycles, next entry requested.
    ifc.issue_valid_i = 1; ifc.issue_instr_i = mk(7'd1, 3'd0, 5'd3); step();
    ifc.issue_instr_i = mk(7'd2, 3'd1, 5'd4); step();
    ifc.issue_valid_i = 0;
    repeat (7) step();
    sample();
    check("t6 before expiry", ifc.timeout_o, 0);
    check("t6 still waiting", ifc.npu_req_valid_o, 0);
    step();
    sample();
    check("t6 timeout", ifc.timeout_o, 1);
    check("t6 next req", ifc.npu_req_valid_o, 1);
    check("t6 no wb", ifc.wb_valid_o, 0);
    step();
    repeat (7) step();
    respond(64'h77);
    sample();
    check("t6 rsp wins wb", ifc.wb_valid_o, 1);
    check("t6 rsp wins rd", ifc.wb_rd_o, 5'd4);
    check("t6 rsp wins no timeout", ifc.timeout_o, 0);
`else
    // Without the watchdog WAIT is unbounded.
    push(mk(7'd1, 3'd0, 5'd3), 64'd1, 64'd2);
    step();
    repeat (30) step();
    sample();
    check("t6 no timeout", ifc.timeout_o, 0);
    check("t6 still busy", ifc.busy_o, 1);
    respond(64'h77);
    sample();
    check("t6 late wb", ifc.wb_valid_o, 1);
    check("t6 late wb_data", ifc.wb_data_o, 64'h77);
`endif

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/npu_cmd_queue.md
Name: npu_cmd_queue

Overview:
Buffers decoded custom-0 NPU instructions from the issue stage and dispatches them one at a time to the NPU over a valid/ready request channel. It matches each NPU response back to its destination register and produces a writeback pulse. It sits between the core decode/issue stage and the NPU datapath. It generalises the fixed MATMUL/CONV encodings into a parametrised, multi-entry command path with flow control.

Parameters:
XLEN, 64, operand and result width
DEPTH, 4, command FIFO entries; power of two, minimum 2
TIMEOUT_CYCLES, 1024, response watchdog limit; used only with NPU_TIMEOUT_EN

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
issue_valid_i  in  1  instruction offered
issue_ready_o  out  1  queue can accept
issue_instr_i  in  32  raw instruction word
issue_rs1_i  in  XLEN  rs1 operand value
issue_rs2_i  in  XLEN  rs2 operand value
illegal_o  out  1  one-cycle pulse: accepted word was not a legal NPU op
npu_req_valid_o  out  1  request valid
npu_req_ready_i  in  1  NPU accepts request
npu_req_op_o  out  2  NPU_OP_MATMUL / NPU_OP_CONV
npu_req_funct3_o  out  3  sub-mode passthrough
npu_req_a_o  out  XLEN  operand A (rs1)
npu_req_b_o  out  XLEN  operand B (rs2)
npu_rsp_valid_i  in  1  NPU result valid (single-cycle)
npu_rsp_data_i  in  XLEN  NPU result
wb_valid_o  out  1  writeback pulse
wb_rd_o  out  5  destination register
wb_data_o  out  XLEN  writeback data
busy_o  out  1  FIFO non-empty or command outstanding
timeout_o  out  1  one-cycle watchdog pulse (tied 0 without macro)

Behaviour:
- Reset state: FIFO empty, pointers and count 0, state IDLE. All outputs 0, except that issue_ready_o is 1.
- issue_ready_o = (count < DEPTH). No same-cycle bypass when full: a full FIFO refuses input even if it pops in the same cycle.
- Accept condition: issue_valid_i && issue_ready_o.
- Decode of an accepted word:
  - opcode == OPCODE_CUSTOM0 with funct7 FUNCT7_MATRIX_MUL maps to MATMUL.
  - opcode == OPCODE_CUSTOM0 with funct7 FUNCT7_CONVOLUTION maps to CONV.
  - Any other word is not enqueued. illegal_o goes high for exactly one cycle after the accept edge.
- Enqueued entry fields: {op, funct3, rd, rs1, rs2}.
- FIFO: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. A simultaneous push and pop leaves count unchanged.
- FSM has states IDLE, WAIT.
  - IDLE: npu_req_valid_o = !empty. The request fields are driven combinationally from the FIFO head.
  - IDLE to WAIT: on npu_req_valid_o && npu_req_ready_i. The head is popped and its rd is latched.
  - WAIT: npu_req_valid_o = 0. Exactly one command is outstanding.
  - WAIT to IDLE: on npu_rsp_valid_i. At the next edge, wb_valid_o = (latched rd != 0) for one cycle, with wb_data_o = npu_rsp_data_i registered.
- Latency:
  - Push into an empty IDLE queue: npu_req_valid_o is high in the cycle after the accept edge.
  - Response: wb_valid_o is high in the cycle after the npu_rsp_valid_i edge.
  - Back-to-back: the next request can be valid in the same cycle the FSM re-enters IDLE.
- rd == 0: the command executes normally and wb_valid_o is suppressed.
- npu_rsp_valid_i while IDLE is spurious and ignored, with no writeback.
- busy_o = !empty || (state == WAIT).
- Reset asserted mid-operation flushes the FIFO and any outstanding command immediately. A response arriving after reset release is ignored.

Optional Feature:
Macro NPU_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, timeout_o pulses for one cycle and the FSM returns to IDLE.
  - The command is dropped, with no writeback.
  - A response arriving in the same cycle as expiry wins: it produces a writeback and no timeout.
- Without the macro: no counter, WAIT is unbounded, and timeout_o is constant 0.

Decomposition:
- Shared package additions:
  - npu_cmd_t packed struct {op[1:0], funct3[2:0], rd[4:0], a[XLEN-1:0], b[XLEN-1:0]}.
  - npu_q_state_e {Q_IDLE, Q_WAIT}.
  - Reuse of OPCODE_CUSTOM0, FUNCT7_MATRIX_MUL, FUNCT7_CONVOLUTION and NPU_OP_*.
- Sub-module npu_cmd_fifo: a generic DEPTH×npu_cmd_t circular buffer with push/pop/full/empty/count, instantiated once.

Test Plan:
- Reset, then push 0x0220828B (MATMUL, rd=5) with rs1=3, rs2=4 -> next cycle req_valid=1, op=01, a=3, b=4. Hold ready=1, then give rsp 0xAB -> wb_valid one cycle later, rd=5, data=0xAB.
- Push 0x0420830B (CONV, rd=6) -> op=10. Push 0x0620828B (funct7=3) -> illegal_o single pulse, count unchanged, no request.
- With npu_req_ready_i=0, push 5 legal ops at DEPTH=4 -> issue_ready_o drops after 4. Then drain with ready=1 and responses -> 4 writebacks in FIFO order.
- Push MATMUL with rd=0 -> request issued, response given, wb_valid stays 0, busy_o falls.
- Assert rst_n=0 while in WAIT with 2 entries queued -> all outputs reset at once. A later rsp_valid yields no writeback.
- NPU_TIMEOUT_EN with TIMEOUT_CYCLES=8: give no response -> timeout_o pulses after 8 WAIT cycles and the next entry is requested. A response on cycle 8 -> writeback and no timeout.
